// File: rtl/md_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding and exception codes.
package md_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        WRITE    = 3'd3,
        EXCPT    = 3'd4
    } state_t;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_DIV0    = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

endpackage

// File: rtl/md_timeout_cnt.sv
// Run-length watchdog: counts cycles while enabled and flags the terminal count TIMEOUT-1.
module md_timeout_cnt #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = enable && (cnt_q == LAST);

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: launches the mult or div unit, waits for its end flag, then writes Hi/Lo.
// Define MD_DIVZERO_CHECK_EN to trap divides by zero before the divider is started.
module md_sequencer
    import md_seq_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_mult,
    input  logic        req_div,
    input  logic        req_divm,
    input  logic [31:0] divisor,
    input  logic        mult_end,
    input  logic        div_end,
    output logic        mult_start,
    output logic        div_start,
    output logic        md_select,
    output logic        div_a_sel,
    output logic        div_b_sel,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        done,
    output logic        excpt,
    output logic [1:0]  excpt_code
);

    state_t     state_q, state_d;
    logic       mult_start_q, mult_start_d;
    logic       div_start_q, div_start_d;
    logic       md_select_q, md_select_d;
    logic       div_sel_q, div_sel_d;
    logic       write_q, write_d;
    logic       excpt_q, excpt_d;
    logic       busy_q, busy_d;
    logic [1:0] code_q, code_d;

    logic running;
    logic first_cycle;
    logic end_flag;
    logic tc;
    logic cnt_clear;
    logic div_zero;

`ifdef MD_DIVZERO_CHECK_EN
    assign div_zero = (divisor == 32'd0);
`else
    logic unused_divisor;
    assign unused_divisor = ^divisor;
    assign div_zero       = 1'b0;
`endif

    assign running   = (state_q == MULT_RUN) || (state_q == DIV_RUN);
    assign cnt_clear = !running;
    // The start pulse marks run cycle 1, where end flags are not yet trusted.
    assign first_cycle = mult_start_q | div_start_q;
    assign end_flag    = (state_q == MULT_RUN) ? mult_end : div_end;

    md_timeout_cnt #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .enable(running),
        .tc    (tc)
    );

    always_comb begin
        state_d     = state_q;
        md_select_d = md_select_q;
        div_sel_d   = div_sel_q;
        code_d      = code_q;
        case (state_q)
            IDLE: begin
                if (req_mult) begin
                    state_d     = MULT_RUN;
                    md_select_d = 1'b1;
                    div_sel_d   = 1'b0;
                    code_d      = EXC_NONE;
                end else if (req_divm || req_div) begin
                    md_select_d = 1'b0;
                    div_sel_d   = req_divm;
                    if (div_zero) begin
                        state_d = EXCPT;
                        code_d  = EXC_DIV0;
                    end else begin
                        state_d = DIV_RUN;
                        code_d  = EXC_NONE;
                    end
                end
            end
            MULT_RUN, DIV_RUN: begin
                if (!first_cycle && end_flag) begin
                    state_d = WRITE;
                end else if (tc) begin
                    state_d = EXCPT;
                    code_d  = EXC_TIMEOUT;
                end
            end
            WRITE, EXCPT: begin
                state_d   = IDLE;
                div_sel_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mult_start_d = (state_q == IDLE) && (state_d == MULT_RUN);
        div_start_d  = (state_q == IDLE) && (state_d == DIV_RUN);
        write_d      = (state_d == WRITE);
        excpt_d      = (state_d == EXCPT);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            md_select_q  <= 1'b0;
            div_sel_q    <= 1'b0;
            write_q      <= 1'b0;
            excpt_q      <= 1'b0;
            busy_q       <= 1'b0;
            code_q       <= EXC_NONE;
        end else begin
            state_q      <= state_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            md_select_q  <= md_select_d;
            div_sel_q    <= div_sel_d;
            write_q      <= write_d;
            excpt_q      <= excpt_d;
            busy_q       <= busy_d;
            code_q       <= code_d;
        end
    end

    assign mult_start = mult_start_q;
    assign div_start  = div_start_q;
    assign md_select  = md_select_q;
    assign div_a_sel  = div_sel_q;
    assign div_b_sel  = div_sel_q;
    assign hi_write   = write_q;
    assign lo_write   = write_q;
    assign done       = write_q;
    assign excpt      = excpt_q;
    assign busy       = busy_q;
    assign excpt_code = code_q;

endmodule
